// File: rtl/sd_read_force_sequencer_pkg.sv
// Shared types and constants for the SD single-block read force sequencer.
package sd_read_force_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RESP,
    ST_WAIT_TOKEN,
    ST_DATA
  } state_e;

  localparam logic [7:0] SD_START_TOKEN = 8'hFE;
  localparam logic [7:0] SD_FILL        = 8'hFF;
  localparam logic [1:0] CMD_START_MASK = 2'b01;
  localparam int         CMD_BYTES      = 6;

  // Byte counter must hold the longer of the data phase and the token wait, plus one headroom bit.
  function automatic int byte_cnt_width(input int block_bytes, input int token_timeout_bytes);
    int longest;
    longest = (block_bytes + 2 > token_timeout_bytes) ? block_bytes + 2 : token_timeout_bytes;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/sd_read_force_sequencer_spi_snoop_deserializer.sv
// Passive SPI mode-0 snooper: synchronises the bus into clk_i and assembles
// MOSI/MISO bytes MSB first, flagging each completed byte and each CS_n rise.
module spi_snoop_deserializer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  input  logic       miso_i,
  output logic       byte_valid_o,
  output logic [7:0] mosi_byte_o,
  output logic [7:0] miso_byte_o,
  output logic       cs_rise_o
);

  // Bit order in the synchroniser vectors: {sck, cs_n, mosi, miso}; CS_n idles high.
  localparam logic [3:0] SYNC_RST = 4'b0100;

  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic       sck_s;
  logic       cs_n_s;
  logic       mosi_s;
  logic       miso_s;
  logic       sck_prev_q;
  logic       cs_prev_q;
  logic       cs_rise_q;
  logic       byte_valid_q;
  logic       sck_rise;
  logic [2:0] bit_cnt_q;
  logic [7:0] mosi_sr_q;
  logic [7:0] miso_sr_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= SYNC_RST;
      sync_q <= SYNC_RST;
    end else begin
      meta_q <= {sck_i, cs_n_i, mosi_i, miso_i};
      sync_q <= meta_q;
    end
  end

  assign {sck_s, cs_n_s, mosi_s, miso_s} = sync_q;
  assign sck_rise = sck_s & ~sck_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_prev_q   <= 1'b0;
      cs_prev_q    <= 1'b1;
      cs_rise_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      bit_cnt_q    <= 3'd0;
      mosi_sr_q    <= 8'd0;
      miso_sr_q    <= 8'd0;
    end else begin
      sck_prev_q   <= sck_s;
      cs_prev_q    <= cs_n_s;
      cs_rise_q    <= cs_n_s & ~cs_prev_q;
      byte_valid_q <= 1'b0;
      if (cs_n_s) begin
        bit_cnt_q <= 3'd0;
      end else if (sck_rise) begin
        mosi_sr_q <= {mosi_sr_q[6:0], mosi_s};
        miso_sr_q <= {miso_sr_q[6:0], miso_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  // The shift registers hold the finished byte until the next SCK rise, long after the strobe.
  assign byte_valid_o = byte_valid_q;
  assign mosi_byte_o  = mosi_sr_q;
  assign miso_byte_o  = miso_sr_q;
  assign cs_rise_o    = cs_rise_q;

endmodule

// File: rtl/sd_read_force_sequencer.sv
// Tracks CMD17 single-block reads on the snooped SD SPI bus and forces SD MOSI
// high for the data block plus CRC16.
module sd_read_force_sequencer
  import sd_read_force_sequencer_pkg::*;
#(
  parameter int BLOCK_BYTES         = 512,
  parameter int RESP_MAX_BYTES      = 8,
  parameter int TOKEN_TIMEOUT_BYTES = 256,
  parameter int READ_CMD_INDEX      = 17
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Enable,
  input  logic i_SPI_SCK,
  input  logic i_SPI_CS_n,
  input  logic i_MOSI_uP,
  input  logic i_MISO_SD,
  output logic o_Read_SD_CTRL,
  output logic o_Busy,
  output logic o_Block_Done,
  output logic o_Err,
  output logic o_Timeout
);

  localparam int CW = byte_cnt_width(BLOCK_BYTES, TOKEN_TIMEOUT_BYTES);
  localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_BYTES);
  localparam logic [CW-1:0] RESP_LAST = CW'(RESP_MAX_BYTES);
  localparam logic [CW-1:0] TOK_LAST  = CW'(TOKEN_TIMEOUT_BYTES);
  localparam logic [CW-1:0] DATA_LAST = CW'(BLOCK_BYTES + 2);

  logic          byte_valid;
  logic [7:0]    mosi_byte;
  logic [7:0]    miso_byte;
  logic          cs_rise;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          ctrl_q, ctrl_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;

  spi_snoop_deserializer u_snoop (
    .clk_i        (i_Clk),
    .rst_i        (i_Rst),
    .sck_i        (i_SPI_SCK),
    .cs_n_i       (i_SPI_CS_n),
    .mosi_i       (i_MOSI_uP),
    .miso_i       (i_MISO_SD),
    .byte_valid_o (byte_valid),
    .mosi_byte_o  (mosi_byte),
    .miso_byte_o  (miso_byte),
    .cs_rise_o    (cs_rise)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    tmo_d   = 1'b0;
    // Disable and CS_n rise both abandon the transaction silently, ahead of any byte.
    if (!i_Enable || cs_rise) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ctrl_d  = 1'b0;
    end else if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (mosi_byte[7:6] == CMD_START_MASK && mosi_byte[5:0] == 6'(READ_CMD_INDEX)) begin
            state_d = ST_CMD;
            cnt_d   = CW'(1);
          end
        end
        ST_CMD: begin
          if (cnt_inc == CMD_LAST) begin
            state_d = ST_RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_RESP: begin
          if (miso_byte == SD_FILL) begin
            if (cnt_inc == RESP_LAST) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
              tmo_d   = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (miso_byte == 8'h00) begin
            state_d = ST_WAIT_TOKEN;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end
        end
        ST_WAIT_TOKEN: begin
          if (miso_byte == SD_START_TOKEN) begin
            state_d = ST_DATA;
            cnt_d   = '0;
            ctrl_d  = 1'b1;
          end else if (miso_byte[7:4] == 4'h0 && miso_byte != 8'h00) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else if (cnt_inc == TOK_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_d   = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_DATA: begin
          if (cnt_inc == DATA_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            ctrl_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ctrl_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // The mux select comes straight from a flop so it cannot glitch.
  assign o_Read_SD_CTRL = ctrl_q;
  assign o_Busy         = (state_q != ST_IDLE);
  assign o_Block_Done   = done_q;
  assign o_Err          = err_q;
  assign o_Timeout      = tmo_q;

endmodule

// File: tb/tb_sd_read_force_sequencer.sv
// Bench for sd_read_force_sequencer: SPI mode-0 bus model driving byte streams,
// with expected outcomes from a byte-level protocol parser.
module tb_sd_read_force_sequencer;

  localparam int BLOCK     = 512;
  localparam int RESP_MAX  = 8;
  localparam int TOK_TO    = 256;
  localparam int READ_IDX  = 17;
  localparam logic [7:0] READ_BYTE = {2'b01, 6'(READ_IDX)};

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic sck;
  logic cs_n;
  logic mosi;
  logic miso;
  logic ctrl;
  logic busy;
  logic done;
  logic err;
  logic tmo;

  always #5 clk = ~clk;

  sd_read_force_sequencer #(
    .BLOCK_BYTES         (BLOCK),
    .RESP_MAX_BYTES      (RESP_MAX),
    .TOKEN_TIMEOUT_BYTES (TOK_TO),
    .READ_CMD_INDEX      (READ_IDX)
  ) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Enable       (en),
    .i_SPI_SCK      (sck),
    .i_SPI_CS_n     (cs_n),
    .i_MOSI_uP      (mosi),
    .i_MISO_SD      (miso),
    .o_Read_SD_CTRL (ctrl),
    .o_Busy         (busy),
    .o_Block_Done   (done),
    .o_Err          (err),
    .o_Timeout      (tmo)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Running event tallies; the main flow works with deltas around each transaction.
  int done_cnt   = 0;
  int err_cnt    = 0;
  int tmo_cnt    = 0;
  int busy_cyc   = 0;
  int forced_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
    if (tmo === 1'b1) tmo_cnt++;
    if (busy === 1'b1) busy_cyc++;
  end

  // Each SCK rise seen with the force active is one SD MOSI bit replaced by 1.
  always @(posedge sck) begin
    if (ctrl === 1'b1) forced_cnt++;
  end

  logic [7:0] tx_mosi[$];
  logic [7:0] tx_miso[$];
  logic       post_ctrl;
  logic       post_busy;
  int         last_forced;

  task automatic push(input logic [7:0] m, input logic [7:0] s);
    tx_mosi.push_back(m);
    tx_miso.push_back(s);
  endtask

  task automatic push_cmd17_rand();
    push(READ_BYTE, 8'hFF);
    for (int i = 0; i < 5; i++) push(8'($urandom), 8'hFF);
  endtask

  task automatic push_cmd17_plan();
    push(8'h51, 8'hFF); push(8'h00, 8'hFF); push(8'h00, 8'hFF);
    push(8'h10, 8'hFF); push(8'h00, 8'hFF); push(8'hFF, 8'hFF);
  endtask

  // Walks the byte stream as the SD protocol describes it: command, R1, token, block.
  function automatic void ref_model(output int e_done, output int e_err, output int e_to,
                                    output int e_forced, output bit e_busy);
    int n, i, fills, waited, k;
    bit resp_ok, got_tok, stop;
    logic [7:0] b;
    n = tx_mosi.size();
    i = 0;
    e_done = 0; e_err = 0; e_to = 0; e_forced = 0; e_busy = 1'b0;
    while (i < n) begin
      if (tx_mosi[i] == READ_BYTE) begin
        e_busy = 1'b1;
        i += 6;
        fills = 0; resp_ok = 1'b0; stop = 1'b0;
        while (!stop && i < n) begin
          b = tx_miso[i]; i++;
          if (b == 8'hFF) begin
            fills++;
            if (fills == RESP_MAX) begin e_to++; stop = 1'b1; end
          end else begin
            stop = 1'b1;
            if (b == 8'h00) resp_ok = 1'b1; else e_err++;
          end
        end
        if (resp_ok) begin
          waited = 0; got_tok = 1'b0; stop = 1'b0;
          while (!stop && i < n) begin
            b = tx_miso[i]; i++;
            if (b == 8'hFE) begin
              got_tok = 1'b1; stop = 1'b1;
            end else if (b[7:4] == 4'h0 && b != 8'h00) begin
              e_err++; stop = 1'b1;
            end else begin
              waited++;
              if (waited == TOK_TO) begin e_to++; stop = 1'b1; end
            end
          end
          if (got_tok) begin
            k = (n - i < BLOCK + 2) ? n - i : BLOCK + 2;
            e_forced += 8 * k;
            i += k;
            if (k == BLOCK + 2) e_done++;
          end
        end
      end else begin
        i++;
      end
    end
  endfunction

  // SPI edges land on clk negedges, half-period 4 clk (the minimum 8x ratio).
  task automatic drive_tx();
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < tx_mosi.size(); i++) begin
      for (int b = 7; b >= 0; b--) begin
        mosi = tx_mosi[i][b];
        miso = tx_miso[i][b];
        #40 sck = 1'b1;
        #40 sck = 1'b0;
      end
    end
    cs_n = 1'b1;
    mosi = 1'b1;
    miso = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    post_ctrl = ctrl;
    post_busy = busy;
    repeat (6) @(posedge clk);
  endtask

  task automatic run_tx(input string tag);
    int e_done, e_err, e_to, e_forced;
    bit e_busy;
    int b_done, b_err, b_to, b_forced, b_busy;
    ref_model(e_done, e_err, e_to, e_forced, e_busy);
    b_done = done_cnt; b_err = err_cnt; b_to = tmo_cnt; b_forced = forced_cnt; b_busy = busy_cyc;
    drive_tx();
    last_forced = forced_cnt - b_forced;
    check({tag, ".done"}, done_cnt - b_done, e_done);
    check({tag, ".err"}, err_cnt - b_err, e_err);
    check({tag, ".timeout"}, tmo_cnt - b_to, e_to);
    check({tag, ".forced_bits"}, last_forced, e_forced);
    check({tag, ".ctrl_after_cs"}, post_ctrl, 0);
    check({tag, ".busy_after_cs"}, post_busy, 0);
    if (!e_busy) check({tag, ".busy_cycles"}, busy_cyc - b_busy, 0);
    tx_mosi.delete();
    tx_miso.delete();
  endtask

  // Stream with a short forced block, used by the mid-DATA reset and disable runs.
  task automatic build_short_read();
    push_cmd17_plan();
    push(8'hFF, 8'h00);
    push(8'hFF, 8'hFE);
    for (int i = 0; i < 12; i++) push(8'hFF, 8'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    int kind, fills, waits, k, b_done;
    logic [5:0] idx;
    rst = 1'b1; en = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b1; miso = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ctrl", ctrl, 0);
    check("reset.busy", busy, 0);
    check("reset.pulses", {done, err, tmo}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle.ctrl", ctrl, 0);
    check("idle.busy", busy, 0);

    // Clean CMD17 with random uP MOSI during the block.
    push_cmd17_plan();
    push(8'hFF, 8'hFF); push(8'hFF, 8'hFF); push(8'hFF, 8'h00);
    push(8'hFF, 8'hFF); push(8'hFF, 8'hFF); push(8'hFF, 8'hFF);
    push(8'hFF, 8'hFE);
    for (int i = 0; i < BLOCK + 2; i++) push(8'($urandom), 8'($urandom));
    run_tx("clean");
    check("clean.forced_const", last_forced, (BLOCK + 2) * 8);

    // CMD24 is not a read.
    push(8'h58, 8'hFF); push(8'h00, 8'hFF); push(8'h00, 8'hFF);
    push(8'h00, 8'hFF); push(8'h00, 8'hFF); push(8'hFD, 8'hFF);
    push(8'hFF, 8'hFF); push(8'hFF, 8'hFF);
    run_tx("cmd24");

    push_cmd17_plan(); push(8'hFF, 8'h05); push(8'hFF, 8'hFF);
    run_tx("r1_err");

    push_cmd17_plan(); push(8'hFF, 8'h00);
    for (int i = 0; i < TOK_TO + 1; i++) push(8'hFF, 8'hFF);
    run_tx("tok_timeout");

    push_cmd17_plan(); push(8'hFF, 8'h00); push(8'hFF, 8'h08); push(8'hFF, 8'hFF);
    run_tx("err_token");

    push_cmd17_plan(); push(8'hFF, 8'h00); push(8'hFF, 8'hFF); push(8'hFF, 8'hFE);
    for (int i = 0; i < 100; i++) push(8'($urandom), 8'($urandom));
    run_tx("cs_abort");

    // Reset asserted between clock edges while the force is active.
    build_short_read();
    fork
      drive_tx();
      begin
        int w;
        w = 0;
        while (ctrl !== 1'b1 && w < 5000) begin @(negedge clk); w++; end
        check("rst_mid.ctrl_seen", ctrl, 1);
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid.ctrl_async", ctrl, 0);
        check("rst_mid.busy_async", busy, 0);
        #20 rst = 1'b0;
      end
    join
    check("rst_mid.ctrl_after_cs", post_ctrl, 0);
    tx_mosi.delete(); tx_miso.delete();

    // Dropping i_Enable mid-block clears the force on the next edge, no done pulse.
    build_short_read();
    b_done = done_cnt;
    fork
      drive_tx();
      begin
        int w;
        w = 0;
        while (ctrl !== 1'b1 && w < 5000) begin @(negedge clk); w++; end
        check("en_abort.ctrl_seen", ctrl, 1);
        repeat (100) @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("en_abort.ctrl", ctrl, 0);
        check("en_abort.busy", busy, 0);
        repeat (20) @(negedge clk);
        en = 1'b1;
      end
    join
    check("en_abort.done", done_cnt - b_done, 0);
    tx_mosi.delete(); tx_miso.delete();

    // Randomised short transactions.
    for (int t = 0; t < 4; t++) begin
      kind  = $urandom_range(0, 4);
      fills = $urandom_range(0, RESP_MAX - 1);
      waits = $urandom_range(0, 10);
      case (kind)
        0: begin
          idx = 6'($urandom_range(0, 63));
          if (idx == 6'(READ_IDX)) idx = idx + 6'd1;
          push({2'b01, idx}, 8'hFF);
          for (int i = 0; i < 5; i++) push(8'($urandom), 8'hFF);
          push(8'hFF, 8'hFF); push(8'hFF, 8'hFF);
        end
        1: begin
          push_cmd17_rand();
          for (int i = 0; i < fills; i++) push(8'hFF, 8'hFF);
          push(8'hFF, 8'($urandom_range(1, 254)));
        end
        2: begin
          push_cmd17_rand();
          for (int i = 0; i < RESP_MAX + 1; i++) push(8'hFF, 8'hFF);
        end
        3: begin
          push_cmd17_rand();
          for (int i = 0; i < fills; i++) push(8'hFF, 8'hFF);
          push(8'hFF, 8'h00);
          for (int i = 0; i < waits; i++) push(8'hFF, 8'hFF);
          push(8'hFF, {4'h0, 4'($urandom_range(1, 15))});
        end
        default: begin
          k = $urandom_range(1, 8);
          push_cmd17_rand();
          for (int i = 0; i < fills; i++) push(8'hFF, 8'hFF);
          push(8'hFF, 8'h00);
          for (int i = 0; i < waits; i++) push(8'hFF, 8'hFF);
          push(8'hFF, 8'hFE);
          for (int i = 0; i < k; i++) push(8'($urandom), 8'($urandom));
        end
      endcase
      run_tx($sformatf("rand%0d_k%0d", t, kind));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
